// File: rtl/load_extend_ctrl_pkg.sv
// Shared definitions for the load-extend controller: size encodings, FSM states
// and the alignment check applied when a request is accepted.
package load_ext_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } state_t;

  // True for an illegal size or an address not aligned to the access size.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      SZ_WORD: bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend_ctrl_if.sv
// Request, memory-read and response signals of the load-extend controller.
// Handshake: a request transfers on the rising edge where req_valid && req_ready;
// mem_rd_en and rsp_valid are single-cycle strobes with no back-pressure.
interface load_extend_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_addr, req_size, req_unsigned, mem_rd_valid, mem_rd_data,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_unsigned, mem_rd_valid, mem_rd_data,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/load_extend_ctrl_subword_extend.sv
// Little-endian lane select of a byte/half/word from a memory word, followed by
// sign or zero extension to 32 bits.
module subword_extend
  import load_ext_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(data >> {addr, 3'b000});
    half_lane = addr[1] ? data[31:16] : data[15:0];
    result    = '0;
    case (size)
      SZ_BYTE: result = {{24{byte_lane[7] & ~zext}}, byte_lane};
      SZ_HALF: result = {{16{half_lane[15] & ~zext}}, half_lane};
      SZ_WORD: result = data;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_extend_ctrl.sv
// Load controller: accepts one load at a time, issues a single aligned memory
// read, waits with a timeout, and returns the lane-selected, extended result.
module load_extend_ctrl
  import load_ext_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  load_extend_ctrl_if.slave     bus,
  output state_t                dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [1:0]     lsb_q;
  logic [1:0]     size_q;
  logic           uns_q;
  logic           err_q;
  logic [31:0]    ext_data;
  logic           req_bad;

  assign req_bad       = req_is_bad(bus.req_size, bus.req_addr[1:0]);
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;

  subword_extend u_ext (
    .data   (bus.mem_rd_data),
    .addr   (lsb_q),
    .size   (size_q),
    .zext   (uns_q),
    .result (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      lsb_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      err_q         <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lsb_q  <= bus.req_addr[1:0];
            size_q <= bus.req_size;
            uns_q  <= bus.req_unsigned;
            err_q  <= req_bad;
            cnt    <= '0;
            state  <= READ;
            if (!req_bad) begin
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
            end
          end
        end
        // A rejected request spends its READ cycle without a strobe, so the
        // error response appears two cycles after acceptance.
        READ: begin
          if (err_q) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_data  <= '0;
            state         <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rd_valid) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= ext_data;
            state         <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_data  <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Directed bench for load_extend_ctrl: reset, lane/extension table, alignment
// errors, timeout boundary and reset during a pending read.
module tb_load_extend_ctrl;
  import load_ext_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     checks = 0;
  int     passed = 0;

  always #5 clk = ~clk;

  load_extend_ctrl_if bus ();

  load_extend_ctrl #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Driver: called at a falling edge with the DUT idle. Presents one request,
  // answers the read in cycle 'ans' (0 = never; cycle 1 follows acceptance),
  // and returns at the falling edge of the cycle after the response.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] d, input int ans,
                          output int rd_cnt, output logic [31:0] maddr, output int rsp_cyc,
                          output int rsp_cnt, output logic [31:0] rdata, output logic rerr,
                          output int bad_hs);
    bus.req_valid    = 1'b1;
    bus.req_addr     = a;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rd_cnt = 0; maddr = 'x; rsp_cyc = -1; rsp_cnt = 0; rdata = 'x; rerr = 1'bx; bad_hs = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin rd_cnt++; maddr = bus.mem_addr; end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin rsp_cyc = k; rdata = bus.rsp_data; rerr = bus.rsp_err; end
      end
      if (bus.req_ready == bus.busy) bad_hs++;
      if ((rsp_cyc < 0 || k == rsp_cyc) && bus.req_ready) bad_hs++;
      if (rsp_cyc > 0 && k == rsp_cyc + 1) break;
      bus.mem_rd_valid = (k == ans);
      bus.mem_rd_data  = (k == ans) ? d : 32'hA5A5_A5A5;
    end
    bus.mem_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = '0; bus.req_unsigned = 1'b0;
    bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.req_ready, bus.mem_rd_en, bus.rsp_valid, bus.rsp_err, bus.busy} !== 5'b10000)
      $display("FAIL reset_flags got %b want 10000", {bus.req_ready, bus.mem_rd_en, bus.rsp_valid, bus.rsp_err, bus.busy}); else passed++;
    checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); else passed++;
    checks++; if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); else passed++;
    checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d want IDLE", dbg_state); else passed++;
  endtask

  task automatic test_lanes();
    logic [31:0] ta[9] = '{32'h103, 32'h102, 32'h100, 32'h101, 32'h102, 32'h100, 32'h102, 32'h104, 32'h2FE};
    logic [1:0]  ts[9] = '{SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_WORD, SZ_HALF};
    logic        tu[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] td[9] = '{32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF, 32'h80FF_1234, 32'h80FF_1234,
                           32'h80FF_1234, 32'h8001_7FFF, 32'hDEAD_BEEF, 32'h1234_5678};
    logic [31:0] tm[9] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h2FC};
    logic [31:0] te[9] = '{32'hFFFF_FF80, 32'h0000_8001, 32'h0000_7FFF, 32'h0000_0012, 32'hFFFF_FFFF,
                           32'h0000_0034, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_1234};
    int rd_cnt, rsp_cyc, rsp_cnt, bad_hs;
    logic [31:0] maddr, rdata;
    logic rerr;
    for (int i = 0; i < 9; i++) begin
      run_load(ta[i], ts[i], tu[i], td[i], 2, rd_cnt, maddr, rsp_cyc, rsp_cnt, rdata, rerr, bad_hs);
      checks++; if (rdata !== te[i]) $display("FAIL lane_data[%0d] got %h want %h", i, rdata, te[i]); else passed++;
      checks++; if (rerr !== 1'b0) $display("FAIL lane_err[%0d] got %b want 0", i, rerr); else passed++;
      checks++; if (rsp_cyc !== 3) $display("FAIL lane_latency[%0d] got %0d want 3", i, rsp_cyc); else passed++;
      checks++; if (rd_cnt !== 1 || maddr !== tm[i])
        $display("FAIL lane_read[%0d] got %0d strobes addr %h want 1 addr %h", i, rd_cnt, maddr, tm[i]); else passed++;
      checks++; if (rsp_cnt !== 1 || bad_hs !== 0)
        $display("FAIL lane_handshake[%0d] got rsp pulses %0d ready/busy errs %0d want 1/0", i, rsp_cnt, bad_hs); else passed++;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL back_to_back[%0d] ready got %b want 1 in cycle 4", i, bus.req_ready); else passed++;
    end
    // Stray read-valid while idle must not disturb the held result.
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_rd_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_data !== 32'h0000_1234 || bus.rsp_valid !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL hold_idle got data %h valid %b state %0d want 00001234 0 IDLE", bus.rsp_data, bus.rsp_valid, dbg_state); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] ta[4] = '{32'h101, 32'h102, 32'h100, 32'h103};
    logic [1:0]  ts[4] = '{SZ_HALF, SZ_WORD, SZ_ILL, SZ_WORD};
    int rd_cnt, rsp_cyc, rsp_cnt, bad_hs;
    logic [31:0] maddr, rdata;
    logic rerr;
    for (int i = 0; i < 4; i++) begin
      run_load(ta[i], ts[i], 1'b0, 32'h1111_1111, 2, rd_cnt, maddr, rsp_cyc, rsp_cnt, rdata, rerr, bad_hs);
      checks++; if (rd_cnt !== 0) $display("FAIL err_no_read[%0d] got %0d strobes want 0", i, rd_cnt); else passed++;
      checks++; if (rerr !== 1'b1 || rdata !== 32'h0)
        $display("FAIL err_rsp[%0d] got err %b data %h want 1 00000000", i, rerr, rdata); else passed++;
      checks++; if (rsp_cyc !== 2 || rsp_cnt !== 1)
        $display("FAIL err_latency[%0d] got cycle %0d pulses %0d want 2 1", i, rsp_cyc, rsp_cnt); else passed++;
    end
  endtask

  task automatic test_timeout();
    int tans[3] = '{0, 16, 17};
    logic        terr[3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] tdat[3] = '{32'h0, 32'h1234_5678, 32'h0};
    int rd_cnt, rsp_cyc, rsp_cnt, bad_hs;
    logic [31:0] maddr, rdata;
    logic rerr;
    for (int i = 0; i < 3; i++) begin
      run_load(32'h200, SZ_WORD, 1'b0, 32'h1234_5678, tans[i], rd_cnt, maddr, rsp_cyc, rsp_cnt, rdata, rerr, bad_hs);
      checks++; if (rsp_cyc !== 17) $display("FAIL timeout_latency[%0d] got %0d want 17", i, rsp_cyc); else passed++;
      checks++; if (rerr !== terr[i] || rdata !== tdat[i])
        $display("FAIL timeout_rsp[%0d] got err %b data %h want %b %h", i, rerr, rdata, terr[i], tdat[i]); else passed++;
      checks++; if (rd_cnt !== 1 || maddr !== 32'h200 || rsp_cnt !== 1 || bad_hs !== 0)
        $display("FAIL timeout_seq[%0d] got strobes %0d addr %h pulses %0d hs %0d want 1 200 1 0", i, rd_cnt, maddr, rsp_cnt, bad_hs); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int rd_cnt, rsp_cyc, rsp_cnt, bad_hs, pulses;
    logic [31:0] maddr, rdata;
    logic rerr;
    bus.req_valid = 1'b1; bus.req_addr = 32'h100; bus.req_size = SZ_WORD; bus.req_unsigned = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== WAIT) $display("FAIL mid_in_wait got %0d want WAIT", dbg_state); else passed++;
    rst = 1'b1;
    #1;
    checks++; if ({bus.req_ready, bus.mem_rd_en, bus.rsp_valid, bus.rsp_err, bus.busy} !== 5'b10000 || dbg_state !== IDLE)
      $display("FAIL mid_reset_flags got %b state %0d want 10000 IDLE", {bus.req_ready, bus.mem_rd_en, bus.rsp_valid, bus.rsp_err, bus.busy}, dbg_state); else passed++;
    checks++; if (bus.mem_addr !== 32'h0 || bus.rsp_data !== 32'h0)
      $display("FAIL mid_reset_regs got addr %h data %h want 0 0", bus.mem_addr, bus.rsp_data); else passed++;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 32'hCAFE_F00D;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      if (bus.rsp_valid) pulses++;
    end
    checks++; if (pulses !== 0 || bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL late_valid got pulses %0d data %h err %b state %0d want 0 0 0 IDLE", pulses, bus.rsp_data, bus.rsp_err, dbg_state); else passed++;
    run_load(32'h0, SZ_BYTE, 1'b0, 32'h0000_007F, 2, rd_cnt, maddr, rsp_cyc, rsp_cnt, rdata, rerr, bad_hs);
    checks++; if (rdata !== 32'h0000_007F || rerr !== 1'b0 || rsp_cyc !== 3)
      $display("FAIL post_reset_load got data %h err %b cycle %0d want 0000007f 0 3", rdata, rerr, rsp_cyc); else passed++;
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_errors();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got %0d/%0d checks", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
